// File: rtl/seg_pkg.sv
// Shared constants, digit record and glyph lookup for the seven-segment display driver.
package seg_pkg;

  localparam int unsigned DIGITS    = 8;
  localparam logic [7:0]  SEG_BLANK = 8'hFF;

  // Converter FSM encoding, kept as plain constants for legacy tools.
  typedef logic [1:0] conv_state_t;
  localparam conv_state_t IDLE   = 2'd0;
  localparam conv_state_t CONV   = 2'd1;
  localparam conv_state_t COMMIT = 2'd2;

  // One display position: a blank flag plus the nibble to render.
  typedef struct packed {
    logic       blank;
    logic [3:0] nibble;
  } digit_t;

  // Active-low g..a pattern for a hex nibble.
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] glyph;
    glyph = 7'b1111111;
    unique case (nib)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      4'hF: glyph = 7'b0001110;
      default: glyph = 7'b1111111;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/bin2bcd16.sv
// Iterative 16-bit binary to 5-digit BCD converter (double dabble), one shift per cycle.
module bin2bcd16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd
);
  import seg_pkg::*;

  conv_state_t state_q, state_d;
  logic [35:0] sr_q, sr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [19:0] adj;
  logic [35:0] pre_shift;

  // Add 3 to every BCD nibble that would overflow past 9 after the next shift.
  always_comb begin
    adj = sr_q[35:16];
    for (int i = 0; i < 5; i++) begin
      if (sr_q[16 + 4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = sr_q[16 + 4*i +: 4] + 4'd3;
      end
    end
    pre_shift = {adj, sr_q[15:0]};
  end

  // Next-state logic: load on start, 16 adjust-and-shift steps, then one commit cycle.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CONV;
          sr_d    = {20'd0, bin};
          cnt_d   = 4'd0;
        end
      end
      CONV: begin
        sr_d  = {pre_shift[34:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = COMMIT;
        end
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Busy also covers the cycle after COMMIT so a full conversion spans 18 cycles.
    busy_d = (state_d != IDLE) || (state_q == COMMIT);
  end

  // Converter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = (state_q == COMMIT);
  assign bcd  = sr_q[35:16];

endmodule

// File: rtl/seg_display_driver.sv
// Multiplexed 8-digit seven-segment driver showing a 16-bit value in hex or unsigned decimal.
module seg_display_driver #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        mode,
  output logic        busy,
  output logic [7:0]  seg_n,
  output logic [7:0]  an_n
);
  import seg_pkg::*;

  localparam int unsigned PW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  logic [15:0] shown_value_q;
  logic        shown_mode_q;
  logic        done_q;
  logic        change;
  logic        conv_start;
  logic        conv_busy;
  logic        conv_done;
  logic [19:0] conv_bcd;

  digit_t [DIGITS-1:0] digits_q, digits_d;
  digit_t [DIGITS-1:0] hex_digits, dec_digits;
  logic                lead_zero;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    seg_q, seg_d;
  logic [7:0]    an_q, an_d;

  assign change = (value != shown_value_q) || (mode != shown_mode_q);
  // The converter sits in IDLE either when not busy or in the cycle right after a commit.
  assign conv_start = change && (!conv_busy || done_q);

  // Capture the value/mode being converted; track the commit cycle to reopen the start window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shown_value_q <= 16'h0000;
      shown_mode_q  <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= conv_done;
      if (conv_start) begin
        shown_value_q <= value;
        shown_mode_q  <= mode;
      end
    end
  end

  bin2bcd16 u_bin2bcd16 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .bin   (value),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Build both candidate digit sets and load the selected one on commit.
  always_comb begin
    lead_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      hex_digits[i] = '{blank: (i >= 4), nibble: 4'h0};
      dec_digits[i] = '{blank: 1'b1, nibble: 4'h0};
    end
    for (int i = 0; i < 4; i++) begin
      hex_digits[i].nibble = shown_value_q[4*i +: 4];
    end
    // Walk from the most significant BCD digit down; digit 0 always stays lit.
    for (int i = 4; i >= 0; i--) begin
      dec_digits[i].nibble = conv_bcd[4*i +: 4];
      lead_zero            = lead_zero && (conv_bcd[4*i +: 4] == 4'h0);
      dec_digits[i].blank  = lead_zero && (i != 0);
    end
    digits_d = digits_q;
    if (conv_done) begin
      digits_d = shown_mode_q ? dec_digits : hex_digits;
    end
  end

  // Digit registers; reset shows hex 0000.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) begin
        digits_q[i] <= '{blank: (i >= 4), nibble: 4'h0};
      end
    end else begin
      digits_q <= digits_d;
    end
  end

  // Scan next-state: pins change only on prescaler wrap, so a slot never shows a torn glyph.
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    an_d    = an_q;
    seg_d   = seg_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      idx_d   = idx_q + 3'd1;
      if (digits_q[idx_q].blank) begin
        an_d  = 8'hFF;
        seg_d = SEG_BLANK;
      end else begin
        an_d  = ~(8'd1 << idx_q);
        seg_d = {1'b1, hex2seg(digits_q[idx_q].nibble)};
      end
    end
  end

  // Scan registers driving the pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= 3'd0;
      an_q    <= 8'hFF;
      seg_q   <= SEG_BLANK;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign busy  = conv_busy;
  assign seg_n = seg_q;
  assign an_n  = an_q;

endmodule
